// File: rtl/decode_stage_pkg.sv
// Shared RV opcode/format definitions and immediate helper for the decode stage.
// Holds the opcode map and format codes used by both the decoder and its bench.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // XLEN-independent part of the decoded bundle
  typedef struct packed {
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    fmt_e       fmt;
    logic       illegal;
  } fields_t;

  // 32-bit sign-extended immediate; the caller widens it to XLEN
  function automatic logic [31:0] imm32_of(input fmt_e fmt, input logic [31:0] i);
    case (fmt)
      FMT_I:   imm32_of = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm32_of = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm32_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm32_of = {i[31:12], 12'b0};
      FMT_J:   imm32_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm32_of = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus signals of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_skid_buffer.sv
// Two-entry (main + skid) valid/ready buffer with flush; full throughput under backpressure.
module decode_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         in_xfer;

  assign in_xfer = in_valid & in_ready & ~flush;

  // in_ready is registered "skid empty" so the fetch side never sees a comb path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
      in_ready  <= 1'b1;
    end else if (!out_valid || out_ready) begin
      in_ready <= 1'b1;
      if (skid_vld) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_vld  <= 1'b0;
      end else if (in_xfer) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data <= in_data;
      skid_vld  <= 1'b1;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= ~skid_vld;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV instruction decode stage: field split, format-selected immediate,
// illegal-opcode flag and PC carried through a skid-buffered handshake.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
    $error("decode_stage: XLEN must be 32 or 64");
  end

  localparam int W = $bits(fields_t) + 2 * XLEN;

  fields_t         dec;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [W-1:0]    pay_in;
  logic [W-1:0]    pay_out;
  fields_t         q;

  always_comb begin
    dec         = '0;
    dec.opcode  = bus.in_instr[6:0];
    dec.rd      = bus.in_instr[11:7];
    dec.funct3  = bus.in_instr[14:12];
    dec.rs1     = bus.in_instr[19:15];
    dec.rs2     = bus.in_instr[24:20];
    dec.funct7  = bus.in_instr[31:25];
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    // every listed opcode ends in 2'b11, so a non-32-bit encoding falls to default
    case (bus.in_instr[6:0])
      OPC_LUI, OPC_AUIPC:                                    dec.fmt = FMT_U;
      OPC_JAL:                                               dec.fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: dec.fmt = FMT_I;
      OPC_BRANCH:                                            dec.fmt = FMT_B;
      OPC_STORE:                                             dec.fmt = FMT_S;
      OPC_OP:                                                dec.fmt = FMT_R;
      default:                                               dec.illegal = 1'b1;
    endcase
    imm32 = imm32_of(dec.fmt, bus.in_instr);
    imm   = XLEN'($signed(imm32));
  end

  assign pay_in = {bus.in_pc, imm, dec};

  decode_skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

  assign q               = pay_out[$bits(fields_t)-1:0];
  assign bus.out_imm     = pay_out[$bits(fields_t) +: XLEN];
  assign bus.out_pc      = pay_out[$bits(fields_t) + XLEN +: XLEN];
  assign bus.out_opcode  = q.opcode;
  assign bus.out_rd      = q.rd;
  assign bus.out_rs1     = q.rs1;
  assign bus.out_rs2     = q.rs2;
  assign bus.out_funct3  = q.funct3;
  assign bus.out_funct7  = q.funct7;
  assign bus.out_fmt     = q.fmt;
  assign bus.out_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table at XLEN=32, one XLEN=64 case,
// reset, backpressure and flush sequences.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus32 ();
  decode_stage_if #(.XLEN(64)) bus64 ();

  decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // addi x(k+1), x0, 0 -- rd tags the stream position
  function automatic logic [31:0] mk(input int k);
    logic [4:0] r;
    r  = 5'(k + 1);
    mk = {12'd0, 5'd0, 3'd0, r, 7'h13};
  endfunction

  initial begin
    logic [4:0] seen[$];
    int idx;

    vecs[0] = '{32'hFFF10093, FMT_I, 32'hFFFFFFFF, 1'b0, 5'd1,  5'd2,  5'd31};
    vecs[1] = '{32'h123452B7, FMT_U, 32'h12345000, 1'b0, 5'd5,  5'd8,  5'd3};
    vecs[2] = '{32'hFFDFF06F, FMT_J, 32'hFFFFFFFC, 1'b0, 5'd0,  5'd31, 5'd29};
    vecs[3] = '{32'h00000463, FMT_B, 32'h00000008, 1'b0, 5'd8,  5'd0,  5'd0};
    vecs[4] = '{32'h00512623, FMT_S, 32'h0000000C, 1'b0, 5'd12, 5'd2,  5'd5};
    vecs[5] = '{32'hFFFFF297, FMT_U, 32'hFFFFF000, 1'b0, 5'd5,  5'd31, 5'd31};
    vecs[6] = '{32'h00000000, FMT_R, 32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0};
    vecs[7] = '{32'h0000007F, FMT_R, 32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0};
    vecs[8] = '{32'h00000033, FMT_R, 32'h00000000, 1'b0, 5'd0,  5'd0,  5'd0};

    bus32.flush = 0; bus32.in_valid = 0; bus32.in_instr = 0; bus32.in_pc = 0; bus32.out_ready = 0;
    bus64.flush = 0; bus64.in_valid = 0; bus64.in_instr = 0; bus64.in_pc = 0; bus64.out_ready = 1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", bus32.in_ready, 0);
    check("rst out_valid", bus32.out_valid, 0);
    check("rst out_fmt", bus32.out_fmt, FMT_R);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", bus32.in_ready, 1);

    // table: one instruction per cycle, out_ready high
    bus32.out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      bus32.in_valid = 1;
      bus32.in_instr = vecs[i].instr;
      bus32.in_pc    = 32'h1000 + 32'(4 * i);
      @(negedge clk);
      check($sformatf("vec%0d valid", i), bus32.out_valid, 1);
      check($sformatf("vec%0d fields", i),
            {bus32.out_fmt, bus32.out_illegal, bus32.out_rd, bus32.out_rs1, bus32.out_rs2},
            {vecs[i].fmt, vecs[i].ill, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
      check($sformatf("vec%0d imm", i), bus32.out_imm, vecs[i].imm);
      check($sformatf("vec%0d pc", i), bus32.out_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("vec%0d opcode", i), bus32.out_opcode, vecs[i].instr[6:0]);
    end
    bus32.in_valid = 0;
    @(negedge clk);
    check("drain out_valid", bus32.out_valid, 0);

    // XLEN=64: U immediate sign-extends past bit 31, wide PC passes through
    bus64.in_valid = 1;
    bus64.in_instr = 32'h800002B7;
    bus64.in_pc    = 64'h1_0000_0000;
    @(negedge clk);
    bus64.in_valid = 0;
    check("x64 valid", bus64.out_valid, 1);
    check("x64 imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    check("x64 pc", bus64.out_pc, 64'h1_0000_0000);
    check("x64 fmt", bus64.out_fmt, FMT_U);

    // backpressure: out_ready low for 4 cycles while 5 instructions stream in
    idx = 0;
    for (int cyc = 0; cyc < 40 && seen.size() < 5; cyc++) begin
      bus32.out_ready = (cyc >= 4);
      if (cyc == 2 || cyc == 3) begin
        check($sformatf("bp in_ready c%0d", cyc), bus32.in_ready, 0);
        check($sformatf("bp hold rd c%0d", cyc), bus32.out_rd, 5'd1);
      end
      if (bus32.out_valid && bus32.out_ready) seen.push_back(bus32.out_rd);
      if (idx < 5) begin
        bus32.in_valid = 1;
        bus32.in_instr = mk(idx);
        bus32.in_pc    = 32'h2000 + 32'(4 * idx);
        if (bus32.in_ready) idx++;
      end else begin
        bus32.in_valid = 0;
      end
      @(negedge clk);
    end
    bus32.in_valid = 0;
    check("bp count", seen.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("bp order%0d", k), (k < seen.size()) ? seen[k] : 5'h1F, 5'(k + 1));
    @(negedge clk);
    check("bp idle", bus32.out_valid, 0);

    // flush with main and skid full and a same-cycle input
    bus32.out_ready = 0;
    bus32.in_valid = 1; bus32.in_instr = mk(10);
    @(negedge clk);
    bus32.in_instr = mk(11);
    @(negedge clk);
    check("fl full in_ready", bus32.in_ready, 0);
    bus32.flush = 1; bus32.in_instr = mk(12);
    @(negedge clk);
    bus32.flush = 0; bus32.in_valid = 0;
    check("fl out_valid", bus32.out_valid, 0);
    check("fl in_ready", bus32.in_ready, 1);
    bus32.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fl gone%0d", k), bus32.out_valid, 0);
    end
    bus32.in_valid = 1; bus32.in_instr = mk(13);
    @(negedge clk);
    bus32.in_valid = 0;
    check("fl next valid", bus32.out_valid, 1);
    check("fl next rd", bus32.out_rd, 5'd14);

    // asynchronous reset mid-operation with a live bundle held
    bus32.out_ready = 0;
    bus32.in_valid = 1; bus32.in_instr = 32'hFFF10093;
    @(negedge clk);
    bus32.in_valid = 0;
    check("mid pre valid", bus32.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_valid", bus32.out_valid, 0);
    check("mid rst in_ready", bus32.in_ready, 0);
    check("mid rst imm", bus32.out_imm, 0);
    check("mid rst fmt", bus32.out_fmt, FMT_R);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid post-rst in_ready", bus32.in_ready, 1);
    check("mid post-rst out_valid", bus32.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the RV core. It sits between fetch and register-read/execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake, and extracts the register and function fields. Unlike a purely combinational field splitter, it selects the single correct immediate by opcode format and sign-extends it to XLEN, classifies the format, flags illegal encodings, and carries the PC alongside. A two-entry skid buffer provides full throughput under backpressure, and the stage supports pipeline flush.

## Interface
- XLEN, 32, datapath width (32 or 64); sets the width of pc and of the immediate sign-extension.
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  instruction/pc valid from fetch.
- in_ready  out  1  stage can accept; reset 0, goes to 1 on the first clock after rst_n deasserts.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded bundle valid; reset 0.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  reset 0.
- out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7  out  7/5/5/5/3/7  raw fields; reset 0.
- out_imm  out  XLEN  format-selected, sign-extended immediate; reset 0.
- out_fmt  out  3  format code (R/I/S/B/U/J); reset R.
- out_illegal  out  1  illegal encoding; reset 0.

## Operation
- Transfer on the input side happens when in_valid && in_ready. Transfer on the output side happens when out_valid && out_ready.
- Decode is combinational on in_instr and is captured at transfer time. Only registered state drives the outputs.
- Format selection by opcode:
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - I: JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011.
  - B: BRANCH 1100011.
  - S: STORE 0100011.
  - R: OP 0110011.
- Immediate construction:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Every immediate is sign-extended from inst[31] to XLEN; for U with XLEN=64, bits 63:32 = inst[31]. R gives out_imm=0.
- out_illegal=1 when inst[1:0]!=2'b11 or the opcode is not in the list above.
  - Illegal instructions still flow with fmt=R and imm=0. Raw fields pass through unmodified.
- Skid buffer: a main (output) register plus one skid register.
  - in_ready is registered and equals "skid empty".
  - When the output is stalled and an input transfer occurs, the data goes to skid. in_ready drops the next cycle.
  - When the output drains, skid moves into main and in_ready rises the next cycle.
- Flush:
  - Clears out_valid and skid occupancy the same edge.
  - Any in_valid in the flush cycle is dropped and not accepted.
  - in_ready is 1 the cycle after the flush.
  - Flush has priority over all other events.
- Reset mid-operation: all valid state clears immediately (asynchronously). Outputs return to their reset values.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid at N+1.
- Throughput is 1 per cycle with out_ready held high.
- Backpressure: with out_ready low, at most 2 instructions are held. in_ready falls within 1 cycle of skid fill, and no instruction is lost or duplicated.
- Simultaneous output transfer and input transfer with skid empty: main is reloaded directly from the input.
- Output is held stable while out_valid && !out_ready; out_* fields must not change.
- XLEN is a static parameter. Only 32 and 64 are legal, checked with an elaboration-time error.

## Structure
- Opcode constants go in the shared riscv_defs.v header (extend it where missing). Format codes go there too: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
- Sub-module decode_skid_buffer is parametrised on payload width. It holds the valid/ready/flush logic; decode_stage packs the decoded bundle into its payload.
- Decode logic is a combinational function/always block in decode_stage.

## Test plan
- Reset: hold rst_n low mid-stream -> out_valid=0, in_ready=0, out_imm=0, out_fmt=R. One cycle after release -> in_ready=1.
- Decode, XLEN=32, one instruction per cycle:
  - 0xFFF10093 (addi x1,x2,-1) -> rd=1, rs1=2, fmt=I, imm=0xFFFFFFFF.
  - 0x123452B7 (lui x5) -> rd=5, fmt=U, imm=0x12345000.
  - 0xFFDFF06F (jal x0,-4) -> fmt=J, imm=0xFFFFFFFC.
  - 0x00000463 (beq x0,x0,8) -> fmt=B, imm=8.
- XLEN=64: 0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000. in_pc=0x1_0000_0000 passes to out_pc.
- Illegal: 0x00000000 -> illegal=1. 0x0000007F -> illegal=1. 0x00000033 (add) -> illegal=0, fmt=R, imm=0.
- Backpressure: stream 5 instructions with out_ready low for 4 cycles -> in_ready=0 after 2 accepted. After release, all 5 appear in order with no duplicates.
- Flush with both registers full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed instructions and the same-cycle input never appear.
